// File: rtl/rle_decoder.sv
// Run-length decoder: reads {count, value} byte pairs over SRAM port A and
// writes the expanded plaintext back through the same port, packed big-endian.
module rle_decoder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, EXPAND, WR, FLUSH, DONE
  } state_t;

  state_t state_q, state_d;
  state_t after_wr_q, after_wr_d;

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]       limit_q, limit_d;
  logic [31:0]       consumed_q, consumed_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pair_sel_q, pair_sel_d;
  logic [31:0]       pack_q, pack_d;
  logic [1:0]        pack_cnt_q, pack_cnt_d;
  logic [31:0]       msg_q, msg_d;

  logic [7:0]  value;
  logic        emit;
  logic        pair_done;
  logic [4:0]  shift;
  state_t      step_next;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rle_addr[31:ADDR_W], rle_addr[1:0],
                              message_addr[31:ADDR_W], message_addr[1:0]};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    after_wr_d = after_wr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    limit_d    = limit_q;
    consumed_d = consumed_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    pair_sel_d = pair_sel_q;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    msg_d      = msg_q;
    value      = pair_sel_q ? word_q[7:0] : word_q[23:16];
    emit       = 1'b0;
    pair_done  = 1'b0;
    shift      = 5'd24 - {pack_cnt_q, 3'b000};
    step_next  = EXPAND;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rd_ptr_d   = {rle_addr[ADDR_W-1:2], 2'b00};
          wr_ptr_d   = {message_addr[ADDR_W-1:2], 2'b00};
          limit_d    = {rle_size[31:1], 1'b0};
          consumed_d = '0;
          msg_d      = '0;
          pack_d     = '0;
          pack_cnt_d = '0;
          pair_sel_d = 1'b0;
          cnt_d      = '0;
          state_d    = (rle_size < 32'd2) ? DONE : RD_REQ;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        word_d     = port_A_data_out[23:0];
        cnt_d      = port_A_data_out[31:24];
        pair_sel_d = 1'b0;
        rd_ptr_d   = rd_ptr_q + ADDR_W'(4);
        state_d    = EXPAND;
      end
      EXPAND: begin
        if (cnt_q != 8'd0) begin
          emit       = 1'b1;
          cnt_d      = cnt_q - 8'd1;
          msg_d      = msg_q + 32'd1;
          pack_d     = pack_q | ({24'd0, value} << shift);
          pack_cnt_d = pack_cnt_q + 2'd1;
        end
        // a zero-count pair is exhausted immediately and costs this one cycle
        pair_done = (cnt_q <= 8'd1);
        if (pair_done) begin
          consumed_d = consumed_q + 32'd2;
          if ({1'b0, consumed_q} + 33'd2 >= {1'b0, limit_q}) begin
            step_next = FLUSH;
          end else if (pair_sel_q) begin
            step_next = RD_REQ;
          end else begin
            pair_sel_d = 1'b1;
            cnt_d      = word_q[15:8];
          end
        end
        if (emit && (pack_cnt_q == 2'd3)) begin
          state_d    = WR;
          after_wr_d = step_next;
        end else begin
          state_d = step_next;
        end
      end
      WR: begin
        pack_d   = '0;
        wr_ptr_d = wr_ptr_q + ADDR_W'(4);
        state_d  = after_wr_q;
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      after_wr_q <= EXPAND;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      limit_q    <= '0;
      consumed_q <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      pair_sel_q <= 1'b0;
      pack_q     <= '0;
      pack_cnt_q <= '0;
      msg_q      <= '0;
    end else begin
      after_wr_q <= after_wr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      limit_q    <= limit_d;
      consumed_q <= consumed_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      pair_sel_q <= pair_sel_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      msg_q      <= msg_d;
    end
  end

  always_comb begin
    port_A_addr    = '0;
    port_A_we      = 1'b0;
    port_A_data_in = '0;
    case (state_q)
      RD_REQ, RD_WAIT: port_A_addr = rd_ptr_q;
      WR: begin
        port_A_addr    = wr_ptr_q;
        port_A_we      = 1'b1;
        port_A_data_in = pack_q;
      end
      FLUSH: begin
        // unused low bytes were cleared when the pack register was last emptied
        if (pack_cnt_q != 2'd0) begin
          port_A_addr    = wr_ptr_q;
          port_A_we      = 1'b1;
          port_A_data_in = pack_q;
        end
      end
      default: ;
    endcase
  end

  assign done         = (state_q == DONE);
  assign message_size = msg_q;
  assign port_A_clk   = clk;

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder with a behavioural 1-cycle-latency SRAM.
module tb_rle_decoder;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       rle_addr = '0;
  logic [31:0]       rle_size = '0;
  logic [31:0]       message_addr = '0;
  logic [31:0]       message_size;
  logic              done;
  logic              port_A_clk;
  logic [ADDR_W-1:0] port_A_addr;
  logic              port_A_we;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;

  rle_decoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .rle_addr(rle_addr), .rle_size(rle_size), .message_addr(message_addr),
    .message_size(message_size), .done(done), .port_A_clk(port_A_clk),
    .port_A_addr(port_A_addr), .port_A_we(port_A_we),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  logic        pl_we = 1'b0;
  logic [13:0] pl_idx = '0;
  logic [31:0] pl_data = '0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (port_A_we) begin
      mem[port_A_addr[15:2]] <= port_A_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    port_A_data_out <= mem[port_A_addr[15:2]];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = addr[15:2]; pl_data = data;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
    @(negedge clk);
    rle_addr = ra; rle_size = rs; message_addr = ma; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int cycles);
    ok = 1'b0; cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin ok = 1'b1; cycles = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors += 5;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (message_size !== 32'd0) begin miscompares++; $display("FAIL reset_msize got=%0d exp=0", message_size); end
    if (port_A_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%0b exp=0", port_A_we); end
    if (port_A_addr !== '0) begin miscompares++; $display("FAIL reset_addr got=%h exp=0", port_A_addr); end
    if (port_A_data_in !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got=%h exp=0", port_A_data_in); end
    nreset = 1'b1;
  endtask

  task automatic test_empty();
    int w0;
    w0 = wr_cnt;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL empty_pre_done got=%0b exp=0", done); end
    pulse_start(32'h100, 32'd0, 32'h200);
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL empty_done_next got=%0b exp=1", done); end
    pulse_start(32'h100, 32'd1, 32'h200);
    repeat (3) @(negedge clk);
    vectors += 3;
    if (done !== 1'b1) begin miscompares++; $display("FAIL empty1_done got=%0b exp=1", done); end
    if (message_size !== 32'd0) begin miscompares++; $display("FAIL empty_msize got=%0d exp=0", message_size); end
    if (wr_cnt !== w0) begin miscompares++; $display("FAIL empty_writes got=%0d exp=0", wr_cnt - w0); end
  endtask

  task automatic test_basic();
    int w0, cyc; bit ok;
    load(32'h100, 32'h03410242);
    load(32'h208, 32'hDEADBEEF);
    w0 = wr_cnt;
    pulse_start(32'h100, 32'd4, 32'h200);
    wait_done(ok, cyc);
    vectors += 7;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout got=no_done exp=done"); end
    if (cyc !== 9) begin miscompares++; $display("FAIL basic_latency got=%0d exp=9", cyc); end
    if (mem[32'h200 >> 2] !== 32'h41414142) begin miscompares++; $display("FAIL basic_w0 got=%h exp=41414142", mem[32'h200 >> 2]); end
    if (mem[32'h204 >> 2] !== 32'h42000000) begin miscompares++; $display("FAIL basic_w1 got=%h exp=42000000", mem[32'h204 >> 2]); end
    if (mem[32'h208 >> 2] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_guard got=%h exp=deadbeef", mem[32'h208 >> 2]); end
    if (message_size !== 32'd5) begin miscompares++; $display("FAIL basic_msize got=%0d exp=5", message_size); end
    if (wr_cnt - w0 !== 2) begin miscompares++; $display("FAIL basic_writes got=%0d exp=2", wr_cnt - w0); end
  endtask

  task automatic test_long_run();
    int w0, cyc, bad; bit ok;
    load(32'h300, 32'hFF5A0000);
    w0 = wr_cnt;
    pulse_start(32'h300, 32'd2, 32'h400);
    wait_done(ok, cyc);
    bad = 0;
    for (int i = 0; i < 63; i++)
      if (mem[(32'h400 >> 2) + i] !== 32'h5A5A5A5A) bad++;
    vectors += 6;
    if (!ok) begin miscompares++; $display("FAIL long_timeout got=no_done exp=done"); end
    if (cyc !== 321) begin miscompares++; $display("FAIL long_latency got=%0d exp=321", cyc); end
    if (bad !== 0) begin miscompares++; $display("FAIL long_full_words got=%0d_bad exp=0_bad", bad); end
    if (mem[(32'h400 >> 2) + 63] !== 32'h5A5A5A00) begin miscompares++; $display("FAIL long_tail got=%h exp=5a5a5a00", mem[(32'h400 >> 2) + 63]); end
    if (message_size !== 32'd255) begin miscompares++; $display("FAIL long_msize got=%0d exp=255", message_size); end
    if (wr_cnt - w0 !== 64) begin miscompares++; $display("FAIL long_writes got=%0d exp=64", wr_cnt - w0); end
  endtask

  task automatic test_zero_odd();
    int w0, cyc; bit ok;
    load(32'h500, 32'h00110141);
    load(32'h504, 32'h07000000);
    load(32'h604, 32'hDEADBEEF);
    w0 = wr_cnt;
    pulse_start(32'h500, 32'd5, 32'h600);
    wait_done(ok, cyc);
    vectors += 6;
    if (!ok) begin miscompares++; $display("FAIL zodd_timeout got=no_done exp=done"); end
    if (cyc !== 5) begin miscompares++; $display("FAIL zodd_latency got=%0d exp=5", cyc); end
    if (mem[32'h600 >> 2] !== 32'h41000000) begin miscompares++; $display("FAIL zodd_w0 got=%h exp=41000000", mem[32'h600 >> 2]); end
    if (mem[32'h604 >> 2] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL zodd_guard got=%h exp=deadbeef", mem[32'h604 >> 2]); end
    if (message_size !== 32'd1) begin miscompares++; $display("FAIL zodd_msize got=%0d exp=1", message_size); end
    if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL zodd_writes got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid();
    int w0, cyc; bit ok;
    load(32'h700, 32'hFF330000);
    pulse_start(32'h700, 32'd2, 32'h800);
    repeat (20) @(negedge clk);
    w0 = wr_cnt;
    #2 nreset = 1'b0;
    #1;
    vectors += 5;
    if (done !== 1'b0) begin miscompares++; $display("FAIL rmid_done got=%0b exp=0", done); end
    if (message_size !== 32'd0) begin miscompares++; $display("FAIL rmid_msize got=%0d exp=0", message_size); end
    if (port_A_we !== 1'b0) begin miscompares++; $display("FAIL rmid_we got=%0b exp=0", port_A_we); end
    if (port_A_addr !== '0) begin miscompares++; $display("FAIL rmid_addr got=%h exp=0", port_A_addr); end
    if (port_A_data_in !== 32'd0) begin miscompares++; $display("FAIL rmid_wdata got=%h exp=0", port_A_data_in); end
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_cnt !== w0) begin miscompares++; $display("FAIL rmid_no_writes got=%0d exp=0", wr_cnt - w0); end
    pulse_start(32'h100, 32'd4, 32'h900);
    wait_done(ok, cyc);
    vectors += 4;
    if (!ok) begin miscompares++; $display("FAIL rmid_redo_timeout got=no_done exp=done"); end
    if (message_size !== 32'd5) begin miscompares++; $display("FAIL rmid_redo_msize got=%0d exp=5", message_size); end
    if (mem[32'h900 >> 2] !== 32'h41414142) begin miscompares++; $display("FAIL rmid_redo_w0 got=%h exp=41414142", mem[32'h900 >> 2]); end
    if (mem[32'h904 >> 2] !== 32'h42000000) begin miscompares++; $display("FAIL rmid_redo_w1 got=%h exp=42000000", mem[32'h904 >> 2]); end
  endtask

  task automatic test_busy_start();
    int w0, cyc; bit ok;
    load(32'hA00, 32'h0C770255);
    load(32'hA04, 32'h01AA0000);
    load(32'hC00, 32'hDEADBEEF);
    w0 = wr_cnt;
    pulse_start(32'hA00, 32'd6, 32'hB00);
    repeat (5) @(negedge clk);
    pulse_start(32'h100, 32'd4, 32'hC00);
    wait_done(ok, cyc);
    vectors += 8;
    if (!ok) begin miscompares++; $display("FAIL busy_timeout got=no_done exp=done"); end
    if (message_size !== 32'd15) begin miscompares++; $display("FAIL busy_msize got=%0d exp=15", message_size); end
    if (mem[32'hB00 >> 2] !== 32'h77777777) begin miscompares++; $display("FAIL busy_w0 got=%h exp=77777777", mem[32'hB00 >> 2]); end
    if (mem[32'hB04 >> 2] !== 32'h77777777) begin miscompares++; $display("FAIL busy_w1 got=%h exp=77777777", mem[32'hB04 >> 2]); end
    if (mem[32'hB08 >> 2] !== 32'h77777777) begin miscompares++; $display("FAIL busy_w2 got=%h exp=77777777", mem[32'hB08 >> 2]); end
    if (mem[32'hB0C >> 2] !== 32'h5555AA00) begin miscompares++; $display("FAIL busy_w3 got=%h exp=5555aa00", mem[32'hB0C >> 2]); end
    if (mem[32'hC00 >> 2] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL busy_guard got=%h exp=deadbeef", mem[32'hC00 >> 2]); end
    if (wr_cnt - w0 !== 4) begin miscompares++; $display("FAIL busy_writes got=%0d exp=4", wr_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_basic();
    test_long_run();
    test_zero_odd();
    test_reset_mid();
    test_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
